// File: rtl/vid_bt656_pkg.sv
// Shared types and constants for the BT.656 sequencer.
// Build option: VID_BT656_PROT_EN enables checking of the XY protection bits.
package vid_bt656_pkg;

  // Parser states: blanking, the three bytes after 0xFF, then the 4:2:2 pair bytes.
  typedef enum logic [2:0] {
    ST_BLANK = 3'd0,
    ST_TRS1  = 3'd1,
    ST_TRS2  = 3'd2,
    ST_TRS3  = 3'd3,
    ST_CB    = 3'd4,
    ST_Y0    = 3'd5,
    ST_CR    = 3'd6,
    ST_Y1    = 3'd7
  } bt656_state_t;

  // Timing reference preamble bytes.
  localparam logic [7:0] TRS_FF = 8'hFF;
  localparam logic [7:0] TRS_00 = 8'h00;

  // Bit positions inside the XY status byte.
  localparam int XY_ONE = 7;
  localparam int XY_F   = 6;
  localparam int XY_V   = 5;
  localparam int XY_H   = 4;
  localparam int XY_P3  = 3;
  localparam int XY_P2  = 2;
  localparam int XY_P1  = 1;
  localparam int XY_P0  = 0;

  // Sync and valid flags that travel alongside the converter pipeline.
  typedef struct packed {
    logic valid;
    logic h;
    logic v;
    logic f;
  } sideband_t;

  // One captured 4:2:2 pair, in stream order.
  typedef struct packed {
    logic [7:0] cb;
    logic [7:0] y0;
    logic [7:0] cr;
    logic [7:0] y1;
  } ycbcr_pair_t;

  // True when the protection nibble agrees with F, V and H.
  function automatic logic xy_prot_ok(input logic [7:0] xy);
    logic f, v, h;
    f = xy[XY_F];
    v = xy[XY_V];
    h = xy[XY_H];
    return (xy[XY_P3] == (v ^ h)) && (xy[XY_P2] == (f ^ h)) &&
           (xy[XY_P1] == (f ^ v)) && (xy[XY_P0] == (f ^ v ^ h));
  endfunction

endpackage

// File: rtl/vid_ycbcr2rgb.sv
// BT.601 studio-range YCbCr to 8-bit RGB converter, LAT cycles deep (LAT >= 2).
// Phase selects which luma sample of the held pair is converted this cycle.
module vid_ycbcr2rgb
  import vid_bt656_pkg::*;
#(
  parameter int LAT = 5
) (
  input  logic        clk,
  input  logic        valid,
  input  logic        phase,
  input  ycbcr_pair_t pair,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  logic signed [9:0] y_off, cb_off, cr_off;
  int                r_acc, g_acc, b_acc;
  logic [23:0]       rgb_pipe [0:LAT-2];

  function automatic logic [7:0] clamp8(input int v);
    if (v < 0)   return 8'h00;
    if (v > 255) return 8'hFF;
    return v[7:0];
  endfunction

  // Stage 1: pick the luma sample and remove the studio-range offsets.
  // NOTE: datapath registers carry no reset; only the sideband valid decides
  // whether their contents are ever shown, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (valid) begin
      y_off  <= $signed({2'b00, (phase ? pair.y1 : pair.y0)}) - 10'sd16;
      cb_off <= $signed({2'b00, pair.cb}) - 10'sd128;
      cr_off <= $signed({2'b00, pair.cr}) - 10'sd128;
    end
  end

  // Matrix in 8.8 fixed point with round-to-nearest.
  // NOTE: every variable written here gets a value before any branch, so no
  // latch can be inferred.
  always_comb begin
    r_acc = 298 * int'(y_off) + 409 * int'(cr_off) + 128;
    g_acc = 298 * int'(y_off) - 100 * int'(cb_off) - 208 * int'(cr_off) + 128;
    b_acc = 298 * int'(y_off) + 516 * int'(cb_off) + 128;
  end

  // Stage 2 clamps to 8 bits, then padding stages bring the depth up to LAT.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's old value.
  always_ff @(posedge clk) begin
    rgb_pipe[0] <= {clamp8(r_acc >>> 8), clamp8(g_acc >>> 8), clamp8(b_acc >>> 8)};
    for (int i = 1; i < LAT - 1; i++) begin
      rgb_pipe[i] <= rgb_pipe[i-1];
    end
  end

  assign {r, g, b} = rgb_pipe[LAT-2];

endmodule

// File: rtl/vid_bt656_seq.sv
// BT.656 byte-stream parser and pair sequencer feeding vid_ycbcr2rgb.
// Sync/valid flags are delayed VID_LAT cycles so they line up with RGB.
// Build option: VID_BT656_PROT_EN checks the XY protection nibble.
module vid_bt656_seq
  import vid_bt656_pkg::*;
#(
  parameter int VID_LAT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_stb,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b,
  output logic        out_valid,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_field,
  output logic        out_sof,
  output logic        stat_err,
  output logic [11:0] stat_line_px
);

  bt656_state_t state, state_nxt;

  logic        is_ff, is_00, xy_ok;
  logic        err_det, flag_upd, trs_enter;
  logic        cap_cb, cap_y0, cap_cr, load_pair;
  logic        flag_f, flag_v, flag_h, v_fell, pre_trs_cb;
  logic [7:0]  cb_q, y0_q, cr_q;
  ycbcr_pair_t pair_q;
  logic        launch_ph0, launch_ph1, conv_valid;
  logic [11:0] px_cnt;
  sideband_t   sb_in, sb_out;
  sideband_t   sb_pipe [VID_LAT];
  logic [7:0]  conv_r, conv_g, conv_b;

  assign is_ff = (in_data == TRS_FF);
  assign is_00 = (in_data == TRS_00);

`ifdef VID_BT656_PROT_EN
  assign xy_ok = in_data[XY_ONE] && xy_prot_ok(in_data);
`else
  assign xy_ok = in_data[XY_ONE];
`endif

  // Parser state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_BLANK;
    else     state <= state_nxt;
  end

  // Parser next state; 0xFF restarts a timing reference from any state.
  always_comb begin
    state_nxt = state;
    if (in_stb) begin
      if (is_ff) begin
        state_nxt = ST_TRS1;
      end else begin
        unique case (state)
          ST_BLANK: state_nxt = ST_BLANK;
          ST_TRS1:  state_nxt = is_00 ? ST_TRS2 : ST_BLANK;
          ST_TRS2:  state_nxt = is_00 ? ST_TRS3 : ST_BLANK;
          ST_TRS3:  state_nxt = (xy_ok && !in_data[XY_H] && !in_data[XY_V]) ? ST_CB : ST_BLANK;
          ST_CB:    state_nxt = ST_Y0;
          ST_Y0:    state_nxt = ST_CR;
          ST_CR:    state_nxt = ST_Y1;
          ST_Y1:    state_nxt = ST_CB;
          default:  state_nxt = ST_BLANK;
        endcase
      end
    end
  end

  // Parser outputs: capture strobes, XY acceptance and error detection.
  always_comb begin
    err_det   = 1'b0;
    flag_upd  = 1'b0;
    trs_enter = 1'b0;
    cap_cb    = 1'b0;
    cap_y0    = 1'b0;
    cap_cr    = 1'b0;
    load_pair = 1'b0;
    if (in_stb) begin
      if (is_ff) begin
        trs_enter = !(state inside {ST_TRS1, ST_TRS2, ST_TRS3});
        err_det   = state inside {ST_Y0, ST_CR, ST_Y1};
      end else begin
        unique case (state)
          ST_TRS1, ST_TRS2: err_det = !is_00;
          ST_TRS3: begin
            err_det  = !xy_ok;
            flag_upd = xy_ok;
          end
          ST_CB:   cap_cb    = 1'b1;
          ST_Y0:   cap_y0    = 1'b1;
          ST_CR:   cap_cr    = 1'b1;
          ST_Y1:   load_pair = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Sync flags from accepted XY bytes, and the sticky "V fell" marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_f <= 1'b0;
      flag_v <= 1'b1;
      flag_h <= 1'b1;
      v_fell <= 1'b0;
    end else begin
      if (flag_upd) begin
        flag_f <= in_data[XY_F];
        flag_v <= in_data[XY_V];
        flag_h <= in_data[XY_H];
      end
      if (flag_upd && flag_v && !in_data[XY_V]) v_fell <= 1'b1;
      else if (out_sof)                          v_fell <= 1'b0;
    end
  end

  // Remember whether the stream was between pairs when the preamble began,
  // so an EAV only reports a line that ended cleanly.
  always_ff @(posedge clk) begin
    if (rst)            pre_trs_cb <= 1'b0;
    else if (trs_enter) pre_trs_cb <= (state == ST_CB);
  end

  // Byte capture and pair register; the pair stays put for both phases.
  always_ff @(posedge clk) begin
    if (cap_cb) cb_q <= in_data;
    if (cap_y0) y0_q <= in_data;
    if (cap_cr) cr_q <= in_data;
    if (load_pair) pair_q <= '{cb: cb_q, y0: y0_q, cr: cr_q, y1: in_data};
  end

  // Two-cycle launch: phase 0 the cycle after the load, phase 1 the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      launch_ph0 <= 1'b0;
      launch_ph1 <= 1'b0;
    end else begin
      launch_ph0 <= load_pair;
      launch_ph1 <= launch_ph0;
    end
  end

  assign conv_valid = launch_ph0 | launch_ph1;

  // Pixel counter, cleared at SAV, saturating at the 12-bit maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      px_cnt <= '0;
    end else if (flag_upd && !in_data[XY_H] && !in_data[XY_V]) begin
      px_cnt <= '0;
    end else if (launch_ph0) begin
      px_cnt <= (px_cnt >= 12'd4094) ? 12'd4095 : px_cnt + 12'd2;
    end
  end

  // Status: error pulse and line width latched at EAV.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_err     <= 1'b0;
      stat_line_px <= '0;
    end else begin
      stat_err <= err_det;
      if (flag_upd && in_data[XY_H] && pre_trs_cb) stat_line_px <= px_cnt;
    end
  end

  assign sb_in = '{valid: conv_valid, h: flag_h, v: flag_v, f: flag_f};

  // Sideband delay line matching the converter depth.
  // NOTE: unlike the pixel data, this array is reset element by element,
  // because a stale valid bit would emit a phantom pixel after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VID_LAT; i++) sb_pipe[i] <= '0;
    end else begin
      sb_pipe[0] <= sb_in;
      for (int i = 1; i < VID_LAT; i++) sb_pipe[i] <= sb_pipe[i-1];
    end
  end

  assign sb_out = sb_pipe[VID_LAT-1];

  vid_ycbcr2rgb #(
    .LAT (VID_LAT)
  ) u_conv (
    .clk   (clk),
    .valid (conv_valid),
    .phase (launch_ph1),
    .pair  (pair_q),
    .r     (conv_r),
    .g     (conv_g),
    .b     (conv_b)
  );

  assign out_valid = sb_out.valid;
  assign out_hs    = sb_out.h;
  assign out_vs    = sb_out.v;
  assign out_field = sb_out.f;
  assign out_sof   = sb_out.valid & v_fell;
  assign out_r     = sb_out.valid ? conv_r : 8'h00;
  assign out_g     = sb_out.valid ? conv_g : 8'h00;
  assign out_b     = sb_out.valid ? conv_b : 8'h00;

endmodule
